// File: rtl/video_pkg.sv
// Shared timing defaults, counter width helper and the registered video output bundle
// for the video controller.
package video_pkg;

  localparam int HDISP_DEF      = 800;
  localparam int VDISP_DEF      = 480;
  localparam int HFP_DEF        = 40;
  localparam int HPULSE_DEF     = 48;
  localparam int HBP_DEF        = 40;
  localparam int VFP_DEF        = 13;
  localparam int VPULSE_DEF     = 3;
  localparam int VBP_DEF        = 29;
  localparam int BLINK_HALF_DEF = 25_000_000;

  localparam int HTOTAL_DEF = HDISP_DEF + HFP_DEF + HPULSE_DEF + HBP_DEF;
  localparam int VTOTAL_DEF = VDISP_DEF + VFP_DEF + VPULSE_DEF + VBP_DEF;

  localparam logic [23:0] RGB_WHITE = 24'hFF_FFFF;
  localparam logic [23:0] RGB_BLACK = 24'h00_0000;

  // Bits needed for a counter running 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;
  } video_out_t;

  localparam video_out_t VIDEO_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, rgb: RGB_BLACK};

endpackage

// File: rtl/hws_if.sv
// Hardware-support bus port used for board integration.
interface hws_if;
  logic [15:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave  (input  address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/video_if.sv
// Raster video port: forwarded pixel clock, syncs, blank and 24-bit colour.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_timing.sv
// Pixel/line counters with sync, blank and 16-pixel grid decode; every output is
// registered so it reflects the counter value of the previous cycle.
module vga_timing
  import video_pkg::*;
#(
  parameter int HDISP  = HDISP_DEF,
  parameter int VDISP  = VDISP_DEF,
  parameter int HFP    = HFP_DEF,
  parameter int HPULSE = HPULSE_DEF,
  parameter int HBP    = HBP_DEF,
  parameter int VFP    = VFP_DEF,
  parameter int VPULSE = VPULSE_DEF,
  parameter int VBP    = VBP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output video_out_t vout
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int XW     = cnt_w(HTOTAL);
  localparam int YW     = cnt_w(VTOTAL);

  localparam logic [XW-1:0] X_LAST   = XW'(HTOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(HDISP);
  localparam logic [XW-1:0] X_SYNC_S = XW'(HDISP + HFP);
  localparam logic [XW-1:0] X_SYNC_E = XW'(HDISP + HFP + HPULSE);
  localparam logic [YW-1:0] Y_LAST   = YW'(VTOTAL - 1);
  localparam logic [YW-1:0] Y_ACT    = YW'(VDISP);
  localparam logic [YW-1:0] Y_SYNC_S = YW'(VDISP + VFP);
  localparam logic [YW-1:0] Y_SYNC_E = YW'(VDISP + VFP + VPULSE);

  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] line_y_q, line_y_d;
  video_out_t    vout_q, vout_d;
  logic          active;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    pix_x_d  = pix_x_q + XW'(1);
    line_y_d = line_y_q;
    if (pix_x_q == X_LAST) begin
      pix_x_d  = '0;
      line_y_d = (line_y_q == Y_LAST) ? '0 : line_y_q + YW'(1);
    end

    active       = (pix_x_q < X_ACT) && (line_y_q < Y_ACT);
    vout_d.hs    = !((pix_x_q >= X_SYNC_S) && (pix_x_q < X_SYNC_E));
    vout_d.vs    = !((line_y_q >= Y_SYNC_S) && (line_y_q < Y_SYNC_E));
    vout_d.blank = active;
    vout_d.rgb   = (active && ((pix_x_q[3:0] == 4'd0) || (line_y_q[3:0] == 4'd0)))
                   ? RGB_WHITE : RGB_BLACK;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (reset) begin
      pix_x_q  <= '0;
      line_y_q <= '0;
      vout_q   <= VIDEO_IDLE;
    end else begin
      pix_x_q  <= pix_x_d;
      line_y_q <= line_y_d;
      vout_q   <= vout_d;
    end
  end

  assign vout = vout_q;

endmodule

// File: rtl/video_top.sv
// Video controller top: KEY[0] reset synchroniser, LED heartbeat, idle hardware-support
// port and the raster generator driving the video port.
module video_top
  import video_pkg::*;
#(
  parameter int HDISP      = HDISP_DEF,
  parameter int VDISP      = VDISP_DEF,
  parameter int HFP        = HFP_DEF,
  parameter int HPULSE     = HPULSE_DEF,
  parameter int HBP        = HBP_DEF,
  parameter int VFP        = VFP_DEF,
  parameter int VPULSE     = VPULSE_DEF,
  parameter int VBP        = VBP_DEF,
  parameter int BLINK_HALF = BLINK_HALF_DEF
) (
  input  logic        FPGA_CLK1_50,
  input  logic [1:0]  KEY,
  output logic [7:0]  LED,
  input  logic [3:0]  SW,
  hws_if.master       hws_ifm,
  video_if.master     video_ifm
);

  localparam int BW = cnt_w(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic          key_meta_q, key_meta_d;
  logic          key_sync_q, key_sync_d;
  logic          reset;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          led0_q, led0_d;
  video_out_t    vout;
  logic          unused_ok;

  always_comb begin
    key_meta_d  = KEY[0];
    key_sync_d  = key_meta_q;
    blink_cnt_d = blink_cnt_q + BW'(1);
    led0_d      = led0_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      led0_d      = ~led0_q;
    end
  end

  // Synchroniser flops carry no reset: they are the source of it.
  always_ff @(posedge FPGA_CLK1_50) begin
    key_meta_q <= key_meta_d;
    key_sync_q <= key_sync_d;
  end

  assign reset = ~key_sync_q;

  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      blink_cnt_q <= '0;
      led0_q      <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      led0_q      <= led0_d;
    end
  end

  assign LED = {7'b0, led0_q};

  vga_timing #(
    .HDISP (HDISP),  .VDISP (VDISP),
    .HFP   (HFP),    .HPULSE(HPULSE), .HBP(HBP),
    .VFP   (VFP),    .VPULSE(VPULSE), .VBP(VBP)
  ) u_timing (
    .clk  (FPGA_CLK1_50),
    .reset(reset),
    .vout (vout)
  );

  assign video_ifm.CLK   = FPGA_CLK1_50;
  assign video_ifm.HS    = vout.hs;
  assign video_ifm.VS    = vout.vs;
  assign video_ifm.BLANK = vout.blank;
  assign video_ifm.RGB   = vout.rgb;

  assign hws_ifm.address   = '0;
  assign hws_ifm.read      = 1'b0;
  assign hws_ifm.write     = 1'b0;
  assign hws_ifm.writedata = '0;

  assign unused_ok = ^{KEY[1], SW, hws_ifm.readdata, hws_ifm.waitrequest};

endmodule

// File: tb/tb_video_top.sv
// Directed bench for video_top in a 160x90 mode with a 4-cycle heartbeat half-period.
module tb_video_top;

  localparam int HT    = 288;
  localparam int VT    = 135;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [3:0] sw;
  logic [7:0] led;
  int tests = 0;
  int fails = 0;
  int p     = 0;

  video_if vif ();
  hws_if   hif ();

  assign hif.readdata    = '0;
  assign hif.waitrequest = 1'b0;

  always #10 clk = ~clk;

  video_top #(
    .HDISP(160), .VDISP(90), .HFP(40), .HPULSE(48), .HBP(40),
    .VFP(13), .VPULSE(3), .VBP(29), .BLINK_HALF(4)
  ) dut (
    .FPGA_CLK1_50(clk),
    .KEY         (key),
    .LED         (led),
    .SW          (sw),
    .hws_ifm     (hif),
    .video_ifm   (vif)
  );

  // p is the raster index of the pixel currently shown on the outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic wait_to(input int x, input int y);
    int tgt;
    tgt = y * HT + x;
    while (p < tgt) tick();
  endtask

  task automatic test_reset();
    key = 2'b10;
    sw  = 4'h0;
    repeat (7) tick();
    tests++; if (vif.HS !== 1'b1) begin fails++; $display("FAIL reset_hs: got %b want 1", vif.HS); end
    tests++; if (vif.VS !== 1'b1) begin fails++; $display("FAIL reset_vs: got %b want 1", vif.VS); end
    tests++; if (vif.BLANK !== 1'b0) begin fails++; $display("FAIL reset_blank: got %b want 0", vif.BLANK); end
    tests++; if (vif.RGB !== 24'h0) begin fails++; $display("FAIL reset_rgb: got %h want 000000", vif.RGB); end
    tests++; if (led !== 8'h00) begin fails++; $display("FAIL reset_led: got %h want 00", led); end
    tests++;
    if ({hif.address, hif.read, hif.write, hif.writedata} !== 50'h0) begin
      fails++; $display("FAIL hws_idle: got %h want 0", {hif.address, hif.read, hif.write, hif.writedata});
    end
    tests++; if (vif.CLK !== clk) begin fails++; $display("FAIL video_clk: got %b want %b", vif.CLK, clk); end
    key[0] = 1'b1;
    tick();
    tick();
    tests++; if (vif.BLANK !== 1'b0) begin fails++; $display("FAIL reset_tail_blank: got %b want 0", vif.BLANK); end
    tick();
    p = 0;
    tests++; if (vif.BLANK !== 1'b1) begin fails++; $display("FAIL first_pix_blank: got %b want 1", vif.BLANK); end
    tests++; if (vif.RGB !== 24'hFFFFFF) begin fails++; $display("FAIL first_pix_rgb: got %h want FFFFFF", vif.RGB); end
    tests++; if ({vif.HS, vif.VS} !== 2'b11) begin fails++; $display("FAIL first_pix_sync: got %b want 11", {vif.HS, vif.VS}); end
  endtask

  task automatic test_heartbeat();
    logic exp;
    for (int i = 0; i < 12; i++) begin
      exp = 1'(((p + 1) / 4) % 2);
      tests++; if (led[0] !== exp) begin fails++; $display("FAIL led0 at %0d: got %b want %b", p, led[0], exp); end
      tests++; if (led[7:1] !== 7'h0) begin fails++; $display("FAIL led_hi at %0d: got %h want 00", p, led[7:1]); end
      tick();
    end
  endtask

  task automatic test_line_timing();
    int blank_cnt, blank_last, hs_low, hs_first, fall1, fall2, rgb_bad;
    blank_cnt = 0; blank_last = -1; hs_low = 0; hs_first = -1; fall1 = -1; fall2 = -1; rgb_bad = 0;
    wait_to(0, 1);
    for (int i = 0; i < HT; i++) begin
      if (vif.BLANK === 1'b1) begin blank_cnt++; blank_last = i; end
      if (vif.HS === 1'b0) begin
        hs_low++;
        if (hs_first < 0) begin hs_first = i; fall1 = p; end
      end
      if (vif.BLANK !== 1'b1 && vif.RGB !== 24'h0) rgb_bad++;
      tick();
    end
    for (int i = 0; i < 600 && fall2 < 0; i++) begin
      if (vif.HS === 1'b0) fall2 = p;
      else tick();
    end
    tests++; if (blank_cnt !== 160) begin fails++; $display("FAIL line_blank_cnt: got %0d want 160", blank_cnt); end
    tests++; if (blank_last !== 159) begin fails++; $display("FAIL line_blank_last: got %0d want 159", blank_last); end
    tests++; if (hs_low !== 48) begin fails++; $display("FAIL line_hs_width: got %0d want 48", hs_low); end
    tests++; if (hs_first !== 200) begin fails++; $display("FAIL line_hs_start: got %0d want 200", hs_first); end
    tests++; if (fall2 - fall1 !== 288) begin fails++; $display("FAIL line_period: got %0d want 288", fall2 - fall1); end
    tests++; if (rgb_bad !== 0) begin fails++; $display("FAIL line_rgb_blanked: got %0d want 0", rgb_bad); end
  endtask

  task automatic test_pattern();
    int          xs [7] = '{0, 5, 170, 16, 3, 8, 200};
    int          ys [7] = '{5, 5, 5, 7, 32, 33, 33};
    logic [23:0] rgbs [7] = '{24'hFFFFFF, 24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0};
    logic        blks [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      wait_to(xs[i], ys[i]);
      tests++;
      if (vif.RGB !== rgbs[i]) begin
        fails++; $display("FAIL pattern_rgb (%0d,%0d): got %h want %h", xs[i], ys[i], vif.RGB, rgbs[i]);
      end
      tests++;
      if (vif.BLANK !== blks[i]) begin
        fails++; $display("FAIL pattern_blank (%0d,%0d): got %b want %b", xs[i], ys[i], vif.BLANK, blks[i]);
      end
    end
  endtask

  task automatic test_midframe_reset();
    wait_to(0, 40);
    tests++; if (vif.BLANK !== 1'b1) begin fails++; $display("FAIL mid_pre_blank: got %b want 1", vif.BLANK); end
    key[0] = 1'b0;
    repeat (3) tick();
    tests++;
    if ({vif.HS, vif.VS, vif.BLANK} !== 3'b110) begin
      fails++; $display("FAIL mid_reset_sync: got %b want 110", {vif.HS, vif.VS, vif.BLANK});
    end
    tests++; if (vif.RGB !== 24'h0) begin fails++; $display("FAIL mid_reset_rgb: got %h want 000000", vif.RGB); end
    tests++; if (led !== 8'h00) begin fails++; $display("FAIL mid_reset_led: got %h want 00", led); end
    repeat (3) tick();
    key[0] = 1'b1;
    repeat (3) tick();
    p = 0;
    tests++;
    if ({vif.BLANK, vif.RGB} !== {1'b1, 24'hFFFFFF}) begin
      fails++; $display("FAIL mid_restart_pix: got %b/%h want 1/FFFFFF", vif.BLANK, vif.RGB);
    end
    wait_to(17, 1);
    tests++;
    if ({vif.BLANK, vif.RGB} !== {1'b1, 24'h0}) begin
      fails++; $display("FAIL mid_restart_17_1: got %b/%h want 1/000000", vif.BLANK, vif.RGB);
    end
  endtask

  task automatic test_frame_timing();
    int   fall1, fall2, rise1, bad_edge, blank_cnt, rgb_bad;
    logic vs_prev;
    fall1 = -1; fall2 = -1; rise1 = -1; bad_edge = 0; blank_cnt = 0; rgb_bad = 0;
    vs_prev = vif.VS;
    for (int i = 0; i < 2 * FRAME + 1000 && fall2 < 0; i++) begin
      tick();
      if (vif.VS !== vs_prev) begin
        if (p % HT != 0) bad_edge++;
        if (vif.VS === 1'b0) begin
          if (fall1 < 0) fall1 = p;
          else fall2 = p;
        end else if (rise1 < 0 && fall1 >= 0) begin
          rise1 = p;
        end
      end
      vs_prev = vif.VS;
      if (fall1 >= 0 && fall2 < 0 && vif.BLANK === 1'b1) blank_cnt++;
      if (vif.BLANK !== 1'b1 && vif.RGB !== 24'h0) rgb_bad++;
    end
    tests++; if (fall2 < 0) begin fails++; $display("FAIL frame_timeout: got no second VS fall want one"); end
    tests++; if (fall1 !== 103 * HT) begin fails++; $display("FAIL vs_start: got %0d want %0d", fall1, 103 * HT); end
    tests++; if (rise1 - fall1 !== 864) begin fails++; $display("FAIL vs_width: got %0d want 864", rise1 - fall1); end
    tests++; if (fall2 - fall1 !== FRAME) begin fails++; $display("FAIL frame_period: got %0d want %0d", fall2 - fall1, FRAME); end
    tests++; if (bad_edge !== 0) begin fails++; $display("FAIL vs_edge_align: got %0d want 0", bad_edge); end
    tests++; if (blank_cnt !== 14400) begin fails++; $display("FAIL frame_active: got %0d want 14400", blank_cnt); end
    tests++; if (rgb_bad !== 0) begin fails++; $display("FAIL frame_rgb_blanked: got %0d want 0", rgb_bad); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded 5 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_heartbeat();
    test_line_timing();
    test_pattern();
    test_midframe_reset();
    test_frame_timing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
